tage_history_tracker: RTL



---
 rtl/tage_history_tracker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tage_history_tracker.sv
// tage_history_tracker
//   Keeps the speculative global branch history for the TAGE prediction port
//   and buffers per-branch prediction metadata in a circular buffer until the
//   branch resolves. Resolved branches retire in order, one per cycle, as
//   TAGE update packets. A mispredicting resolve repairs the history from
//   the branch's snapshot and squashes every younger in-flight slot.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   IN_pred*          conditional branch prediction from fetch/TAGE
//   OUT_predHistory   speculative history driven to TAGE
//   OUT_predReady     a free slot exists (registered count only)
//   OUT_predIdx       slot an accepted prediction is written to (tail)
//   IN_resolve*       branch execution result (slot index + direction)
//   OUT_mispredict    one-cycle pulse after a history repair
//   OUT_write*        one-cycle TAGE update packet for the retiring branch
module tage_history_tracker #(
   parameter int HIST_LEN    = 64,
   parameter int NUM_ENTRIES = 8,
   parameter int ADDR_W      = 31,
   parameter int TAGEID_W    = 2,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                IN_predValid,
   input  logic [ADDR_W-1:0]   IN_predAddr,
   input  logic [TAGEID_W-1:0] IN_predTageID,
   input  logic                IN_predTaken,
   input  logic                IN_predAltPred,
   output logic [HIST_LEN-1:0] OUT_predHistory,
   output logic                OUT_predReady,
   output logic [IDX_W-1:0]    OUT_predIdx,
   input  logic                IN_resolveValid,
   input  logic [IDX_W-1:0]    IN_resolveIdx,
   input  logic                IN_resolveTaken,
   output logic                OUT_mispredict,
   output logic                OUT_writeValid,
   output logic [ADDR_W-1:0]   OUT_writeAddr,
   output logic [HIST_LEN-1:0] OUT_writeHistory,
   output logic [TAGEID_W-1:0] OUT_writeTageID,
   output logic                OUT_writeTaken,
   output logic                OUT_writePred,
   output logic                OUT_writeAltPred
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] entValid;
   logic [NUM_ENTRIES-1:0] entResolved;
   logic [NUM_ENTRIES-1:0] entPred;
   logic [NUM_ENTRIES-1:0] entAltPred;
   logic [NUM_ENTRIES-1:0] entTaken;
   logic [ADDR_W-1:0]      entAddr   [NUM_ENTRIES];
   logic [HIST_LEN-1:0]    entSnap   [NUM_ENTRIES];
   logic [TAGEID_W-1:0]    entTageID [NUM_ENTRIES];

   logic [IDX_W-1:0]    head;
   logic [IDX_W-1:0]    tail;
   logic [IDX_W:0]      count;
   logic [HIST_LEN-1:0] hist;

   logic                   resolveHit;
   logic                   mispredictNow;
   logic                   accept;
   logic                   commit;
   logic [IDX_W-1:0]       resolveAge;
   logic [IDX_W-1:0]       slotAge [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] youngerMask;
   logic [IDX_W:0]         countBase;
   logic [IDX_W:0]         countNext;

   assign OUT_predHistory = hist;
   assign OUT_predIdx     = tail;
   assign OUT_predReady   = (count < FULL_COUNT);

   assign resolveHit    = IN_resolveValid && entValid[IN_resolveIdx] && !entResolved[IN_resolveIdx];
   assign mispredictNow = resolveHit && (IN_resolveTaken != entPred[IN_resolveIdx]);
   assign accept        = IN_predValid && OUT_predReady && !mispredictNow;
   assign commit        = entValid[head] && entResolved[head];

   // Ages are measured from head modulo NUM_ENTRIES, so "younger than the
   // resolving slot" is a plain magnitude compare that survives index wrap.
   assign resolveAge = IN_resolveIdx - head;

   always_comb begin
      youngerMask = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         slotAge[i]     = IDX_W'(i) - head;
         youngerMask[i] = (slotAge[i] > resolveAge);
      end
   end

   // The resolving slot stays live, hence the +1 on the mispredict recompute.
   always_comb begin
      if (mispredictNow)
         countBase = {1'b0, resolveAge} + (IDX_W+1)'(1);
      else
         countBase = count + (IDX_W+1)'(accept);
      countNext = countBase - (IDX_W+1)'(commit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entValid         <= '0;
         entResolved      <= '0;
         entPred          <= '0;
         entAltPred       <= '0;
         entTaken         <= '0;
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            entAddr[i]   <= '0;
            entSnap[i]   <= '0;
            entTageID[i] <= '0;
         end
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         hist             <= '0;
         OUT_mispredict   <= 1'b0;
         OUT_writeValid   <= 1'b0;
         OUT_writeAddr    <= '0;
         OUT_writeHistory <= '0;
         OUT_writeTageID  <= '0;
         OUT_writeTaken   <= 1'b0;
         OUT_writePred    <= 1'b0;
         OUT_writeAltPred <= 1'b0;
      end else begin
         OUT_mispredict <= mispredictNow;
         OUT_writeValid <= commit;
         count          <= countNext;

         if (commit) begin
            OUT_writeAddr    <= entAddr[head];
            OUT_writeHistory <= entSnap[head];
            OUT_writeTageID  <= entTageID[head];
            OUT_writeTaken   <= entTaken[head];
            OUT_writePred    <= entPred[head];
            OUT_writeAltPred <= entAltPred[head];
            entValid[head]   <= 1'b0;
            head             <= head + IDX_W'(1);
         end

         if (resolveHit) begin
            entResolved[IN_resolveIdx] <= 1'b1;
            entTaken[IN_resolveIdx]    <= IN_resolveTaken;
         end

         if (mispredictNow) begin
            hist <= {entSnap[IN_resolveIdx][HIST_LEN-2:0], IN_resolveTaken};
            tail <= IN_resolveIdx + IDX_W'(1);
            for (int unsigned i = 0; i < NUM_ENTRIES; i++)
               if (youngerMask[i])
                  entValid[i] <= 1'b0;
         end else if (accept) begin
            entValid[tail]    <= 1'b1;
            entResolved[tail] <= 1'b0;
            entAddr[tail]     <= IN_predAddr;
            entSnap[tail]     <= hist;
            entTageID[tail]   <= IN_predTageID;
            entPred[tail]     <= IN_predTaken;
            entAltPred[tail]  <= IN_predAltPred;
            entTaken[tail]    <= 1'b0;
            tail              <= tail + IDX_W'(1);
            hist              <= {hist[HIST_LEN-2:0], IN_predTaken};
         end
      end
   end

endmodule
